// File: rtl/butterfly_sched_pkg.sv
// Shared types and Q0.7 helpers for the radix-2 butterfly sequencer.
package butterfly_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef logic [1:0] pass_t;

  localparam logic signed [7:0] Q07_MAX = 8'sh7F;
  localparam logic signed [7:0] Q07_MIN = 8'sh80;

  // -128 has no positive Q0.7 counterpart, so it clamps to +127.
  function automatic logic signed [7:0] sat_neg(input logic signed [7:0] v);
    return (v == Q07_MIN) ? Q07_MAX : -v;
  endfunction

endpackage

// File: rtl/butterfly_sched.sv
// Drives an external 5-operand ALU through four passes per butterfly
// (X = A + W*B, Y = A - W*B) and collects the results behind a valid/ready port.
module butterfly_sched
  import butterfly_sched_pkg::*;
#(
  parameter int BUS_WIDTH = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic signed [BUS_WIDTH-1:0]       in_ar,
  input  logic signed [BUS_WIDTH-1:0]       in_ai,
  input  logic signed [BUS_WIDTH-1:0]       in_br,
  input  logic signed [BUS_WIDTH-1:0]       in_bi,
  input  logic signed [BUS_WIDTH-1:0]       in_wr,
  input  logic signed [BUS_WIDTH-1:0]       in_wi,
  input  logic                              in_bypass,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic signed [BUS_WIDTH-1:0]       out_xr,
  output logic signed [BUS_WIDTH-1:0]       out_xi,
  output logic signed [BUS_WIDTH-1:0]       out_yr,
  output logic signed [BUS_WIDTH-1:0]       out_yi,
  output logic        [4:0][BUS_WIDTH-1:0]  alu_ops,
  output logic        [4:0]                 alu_reg_en,
  output logic                              alu_f_add,
  input  logic        [BUS_WIDTH-1:0]       alu_result,
  output logic                              busy
);

  typedef logic signed [BUS_WIDTH-1:0] word_t;
  typedef logic [4:0][BUS_WIDTH-1:0]   ops_t;

  // Operand set {a, b, c, d, e} for one pass; bypass routes one A/B component
  // to a, c and e with zero twiddles so either e-mux polarity yields it.
  function automatic ops_t pass_ops(input pass_t p, input logic byp,
                                    input word_t ar, input word_t ai,
                                    input word_t br, input word_t bi,
                                    input word_t wr, input word_t wi);
    ops_t  o;
    word_t v;
    o = '0;
    if (byp) begin
      case (p)
        2'd0:    v = ar;
        2'd1:    v = ai;
        2'd2:    v = br;
        default: v = bi;
      endcase
      o[0] = v;
      o[2] = v;
      o[4] = v;
    end else begin
      o[0] = br;
      o[2] = bi;
      case (p)
        2'd0:    begin o[1] = wr;          o[3] = sat_neg(wi); o[4] = ar; end
        2'd1:    begin o[1] = wi;          o[3] = wr;          o[4] = ai; end
        2'd2:    begin o[1] = sat_neg(wr); o[3] = wi;          o[4] = ar; end
        default: begin o[1] = sat_neg(wi); o[3] = sat_neg(wr); o[4] = ai; end
      endcase
    end
    return o;
  endfunction

  state_e state_q;
  pass_t  pass_q;
  pass_t  cap_pass_q;
  logic   cap_vld_q;
  ops_t   ops_q, ops_d;
  logic [4:0] reg_en_q;
  logic   f_add_q;
  logic   out_valid_q;
  word_t  ar_q, ai_q, br_q, bi_q, wr_q, wi_q;
  logic   byp_q;
  word_t  xr_q, xi_q, yr_q, yi_q;

  assign in_ready = (state_q == IDLE);

  // Operands for the pass issued next cycle: pass 0 straight from the
  // request inputs, later passes from the latched copy.
  always_comb begin
    ops_d = '0;
    if (state_q == IDLE)
      ops_d = pass_ops(2'd0, in_bypass, in_ar, in_ai, in_br, in_bi, in_wr, in_wi);
    else if (state_q == ISSUE && pass_q != 2'd3)
      ops_d = pass_ops(pass_q + 2'd1, byp_q, ar_q, ai_q, br_q, bi_q, wr_q, wi_q);
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && in_valid) begin
      ar_q  <= in_ar;
      ai_q  <= in_ai;
      br_q  <= in_br;
      bi_q  <= in_bi;
      wr_q  <= in_wr;
      wi_q  <= in_wi;
      byp_q <= in_bypass;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pass_q      <= 2'd0;
      cap_vld_q   <= 1'b0;
      cap_pass_q  <= 2'd0;
      ops_q       <= '0;
      reg_en_q    <= '0;
      f_add_q     <= 1'b0;
      out_valid_q <= 1'b0;
      xr_q        <= '0;
      xi_q        <= '0;
      yr_q        <= '0;
      yi_q        <= '0;
    end else begin
      // The ALU result lags its issue by one cycle, so capture follows a
      // delayed copy of the pass index.
      cap_vld_q  <= (state_q == ISSUE);
      cap_pass_q <= pass_q;
      if (cap_vld_q) begin
        case (cap_pass_q)
          2'd0:    xr_q <= alu_result;
          2'd1:    xi_q <= alu_result;
          2'd2:    yr_q <= alu_result;
          default: yi_q <= alu_result;
        endcase
      end
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_q  <= ISSUE;
            pass_q   <= 2'd0;
            ops_q    <= ops_d;
            reg_en_q <= 5'h1F;
            f_add_q  <= in_bypass;
          end
        end
        ISSUE: begin
          if (pass_q == 2'd3) begin
            state_q  <= DRAIN;
            pass_q   <= 2'd0;
            ops_q    <= '0;
            reg_en_q <= '0;
            f_add_q  <= 1'b0;
          end else begin
            pass_q <= pass_q + 2'd1;
            ops_q  <= ops_d;
          end
        end
        DRAIN: begin
          state_q     <= DONE;
          out_valid_q <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_ops    = ops_q;
  assign alu_reg_en = reg_en_q;
  assign alu_f_add  = f_add_q;
  assign out_valid  = out_valid_q;
  assign out_xr     = xr_q;
  assign out_xi     = xi_q;
  assign out_yr     = yr_q;
  assign out_yi     = yi_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_butterfly_sched.sv
// Bench for butterfly_sched: behavioural ALU stub, table vectors, corner
// sequences and random requests checked against a complex-arithmetic model.
module tb_butterfly_sched;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_ready, in_bypass;
  logic signed [7:0] in_ar, in_ai, in_br, in_bi, in_wr, in_wi;
  logic out_valid, out_ready;
  logic signed [7:0] out_xr, out_xi, out_yr, out_yi;
  logic [4:0][7:0] alu_ops;
  logic [4:0] alu_reg_en;
  logic alu_f_add;
  logic [7:0] alu_result;
  logic busy;

  always #5 clk = ~clk;

  butterfly_sched #(.BUS_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ar(in_ar), .in_ai(in_ai), .in_br(in_br), .in_bi(in_bi),
    .in_wr(in_wr), .in_wi(in_wi), .in_bypass(in_bypass),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_xr(out_xr), .out_xi(out_xi), .out_yr(out_yr), .out_yi(out_yi),
    .alu_ops(alu_ops), .alu_reg_en(alu_reg_en), .alu_f_add(alu_f_add),
    .alu_result(alu_result), .busy(busy)
  );

  // ALU stub: registered operands, result = (a*b + c*d)/128 (floor) + e, wrapped.
  logic signed [7:0] alu_r [5];
  int alu_sum;
  always_ff @(posedge clk) begin
    for (int i = 0; i < 5; i++)
      if (alu_reg_en[i]) alu_r[i] <= alu_ops[i];
  end
  always_comb begin
    alu_sum = ((int'(alu_r[0]) * int'(alu_r[1]) + int'(alu_r[2]) * int'(alu_r[3])) >>> 7)
              + int'(alu_r[4]);
  end
  assign alu_result = alu_sum[7:0];

  typedef struct {
    logic signed [7:0] ar, ai, br, bi, wr, wi;
    logic              byp;
    logic signed [7:0] xr, xi, yr, yi;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;
  logic [4:0][7:0] ops_hist [1:6];
  vec_t tbl [4];

  task automatic chk(input string nm, input longint got, input longint exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(int ar, int ai, int br, int bi, int wr, int wi, int byp,
                              int xr, int xi, int yr, int yi);
    vec_t v;
    v.ar = 8'(ar); v.ai = 8'(ai); v.br = 8'(br); v.bi = 8'(bi);
    v.wr = 8'(wr); v.wi = 8'(wi); v.byp = 1'(byp);
    v.xr = 8'(xr); v.xi = 8'(xi); v.yr = 8'(yr); v.yi = 8'(yi);
    return v;
  endfunction

  function automatic int wrap8(int x);
    logic [7:0] b;
    b = x[7:0];
    return int'($signed(b));
  endfunction

  function automatic int sn(int v);
    return (v == -128) ? 127 : -v;
  endfunction

  // X = A + W*B, Y = A - W*B, with -W formed by saturating negation.
  function automatic vec_t ref_bfly(vec_t v);
    vec_t r;
    int ar, ai, br, bi, wr, wi;
    r = v;
    ar = v.ar; ai = v.ai; br = v.br; bi = v.bi; wr = v.wr; wi = v.wi;
    if (v.byp) begin
      r.xr = v.ar; r.xi = v.ai; r.yr = v.br; r.yi = v.bi;
    end else begin
      r.xr = 8'(wrap8(ar + ((br * wr + bi * sn(wi)) >>> 7)));
      r.xi = 8'(wrap8(ai + ((br * wi + bi * wr) >>> 7)));
      r.yr = 8'(wrap8(ar + ((br * sn(wr) + bi * wi) >>> 7)));
      r.yi = 8'(wrap8(ai + ((br * sn(wi) + bi * sn(wr)) >>> 7)));
    end
    return r;
  endfunction

  task automatic check_outs(input string nm, input vec_t v);
    chk({nm, " xr"}, longint'(out_xr), longint'(v.xr));
    chk({nm, " xi"}, longint'(out_xi), longint'(v.xi));
    chk({nm, " yr"}, longint'(out_yr), longint'(v.yr));
    chk({nm, " yi"}, longint'(out_yi), longint'(v.yi));
  endtask

  task automatic randomize_inputs();
    in_ar = 8'($urandom); in_ai = 8'($urandom); in_br = 8'($urandom);
    in_bi = 8'($urandom); in_wr = 8'($urandom); in_wi = 8'($urandom);
    in_bypass = 1'($urandom);
  endtask

  // One full request: handshake, per-cycle issue checks, optional DONE stall.
  task automatic do_req(input vec_t v, input int stall, input string nm);
    for (int k = 0; k < 20 && !in_ready; k++) step();
    chk({nm, " in_ready before request"}, longint'(in_ready), 1);
    in_ar = v.ar; in_ai = v.ai; in_br = v.br; in_bi = v.bi;
    in_wr = v.wr; in_wi = v.wi; in_bypass = v.byp;
    in_valid = 1'b1;
    out_ready = (stall == 0);
    step();
    in_valid = 1'b0;
    randomize_inputs();
    for (int c = 1; c <= 6; c++) begin
      ops_hist[c] = alu_ops;
      chk($sformatf("%s reg_en c%0d", nm, c), longint'(alu_reg_en), (c <= 4) ? 31 : 0);
      chk($sformatf("%s f_add c%0d", nm, c), longint'(alu_f_add), (c <= 4) ? longint'(v.byp) : 0);
      chk($sformatf("%s out_valid c%0d", nm, c), longint'(out_valid), (c == 6) ? 1 : 0);
      chk($sformatf("%s busy c%0d", nm, c), longint'(busy), 1);
      if (c >= 5) chk($sformatf("%s ops idle c%0d", nm, c), longint'(alu_ops), 0);
      if (c < 6) step();
    end
    check_outs(nm, v);
    for (int s = 0; s < stall; s++) begin
      chk($sformatf("%s stall out_valid s%0d", nm, s), longint'(out_valid), 1);
      chk($sformatf("%s stall in_ready s%0d", nm, s), longint'(in_ready), 0);
      check_outs($sformatf("%s stall s%0d", nm, s), v);
      if (s == 3) begin
        in_valid = 1'b1;
        randomize_inputs();
      end
      step();
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    chk({nm, " out_valid at transfer"}, longint'(out_valid), 1);
    step();
    chk({nm, " out_valid after transfer"}, longint'(out_valid), 0);
    chk({nm, " in_ready after transfer"}, longint'(in_ready), 1);
    check_outs({nm, " held"}, v);
  endtask

  initial begin
    logic [4:0][7:0] exp_ops;
    vec_t rv;

    tbl[0] = mk(10, -4, 20, 8, 64, -64, 0,   24, -10, -4, 2);
    tbl[1] = mk(5, -7, 100, -128, 0, 0, 1,   5, -7, 100, -128);
    tbl[2] = mk(0, 0, 64, 0, -128, 0, 0,     -64, 0, 63, 0);
    tbl[3] = mk(100, 100, 100, 0, 127, 0, 0, -57, 100, 0, 100);

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_ar = '0; in_ai = '0; in_br = '0; in_bi = '0; in_wr = '0; in_wi = '0;
    in_bypass = 1'b0;
    repeat (3) step();
    chk("reset busy", longint'(busy), 0);
    chk("reset out_valid", longint'(out_valid), 0);
    chk("reset reg_en", longint'(alu_reg_en), 0);
    chk("reset ops", longint'(alu_ops), 0);
    chk("reset out_xr", longint'(out_xr), 0);
    rst_n = 1'b1;
    step();
    chk("reset in_ready", longint'(in_ready), 1);

    for (int i = 0; i < 4; i++) do_req(tbl[i], 0, $sformatf("tbl%0d", i));

    // Pass ordering of the reference butterfly.
    do_req(tbl[0], 0, "order");
    exp_ops[0] = 8'd20; exp_ops[1] = 8'd64; exp_ops[2] = 8'd8;
    exp_ops[3] = 8'd64; exp_ops[4] = 8'd10;
    chk("ops cycle1", longint'(ops_hist[1]), longint'(exp_ops));
    exp_ops[3] = 8'hC0; exp_ops[4] = 8'hFC;
    chk("ops cycle4", longint'(ops_hist[4]), longint'(exp_ops));

    do_req(tbl[2], 0, "satneg");
    chk("satneg ops[1] p2", longint'(ops_hist[3][1]), 127);

    do_req(tbl[0], 10, "stall");
    do_req(tbl[3], 0, "after stall");

    // Reset asserted during ISSUE.
    in_ar = tbl[0].ar; in_ai = tbl[0].ai; in_br = tbl[0].br; in_bi = tbl[0].bi;
    in_wr = tbl[0].wr; in_wi = tbl[0].wi; in_bypass = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    step();
    chk("midrst busy", longint'(busy), 0);
    chk("midrst out_valid", longint'(out_valid), 0);
    chk("midrst reg_en", longint'(alu_reg_en), 0);
    chk("midrst ops", longint'(alu_ops), 0);
    chk("midrst out_xr", longint'(out_xr), 0);
    rst_n = 1'b1;
    step();
    chk("midrst in_ready", longint'(in_ready), 1);
    do_req(tbl[0], 0, "post reset");

    for (int i = 0; i < 40; i++) begin
      rv.ar = 8'($urandom); rv.ai = 8'($urandom); rv.br = 8'($urandom);
      rv.bi = 8'($urandom); rv.wr = 8'($urandom); rv.wi = 8'($urandom);
      if ($urandom_range(0, 7) == 0) rv.wr = 8'sh80;
      if ($urandom_range(0, 7) == 0) rv.wi = 8'sh80;
      rv.byp = ($urandom_range(0, 3) == 0);
      rv = ref_bfly(rv);
      do_req(rv, int'($urandom_range(0, 3)), $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/butterfly_sched.md
# butterfly_sched

Sequencer that drives the shared 5-operand ALU (result = a·b + c·d + e; a, c, e integer; b, d Q0.7 twiddle) through one radix-2 complex butterfly per request: X = A + W·B, Y = A − W·B. It accepts operands on a valid/ready input and issues four ALU passes (Xr, Xi, Yr, Yi), generating the operand muxing, `reg_en` and `f_add`. It captures each ALU result and presents the four outputs on a valid/ready output. A bypass request copies A and B straight through the ALU. The block sits between the FFT stage memory/address logic and the ALU instance; the ALU is instantiated alongside it at the top level, not inside it.

## Interface
- BUS_WIDTH, 8, datapath width; only 8 is supported, because the ALU arithmetic is fixed Q7.0/Q0.7.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid / in_ready  in / out  1  request handshake; transfer occurs when both are high on a rising edge.
- in_ar, in_ai, in_br, in_bi  in  BUS_WIDTH  A and B, signed integer.
- in_wr, in_wi  in  BUS_WIDTH  twiddle W, signed Q0.7.
- in_bypass  in  1  1 = output X = A, Y = B (no multiply).
- out_valid / out_ready  out / in  1  result handshake.
- out_xr, out_xi, out_yr, out_yi  out  BUS_WIDTH  butterfly results.
- alu_ops  out  [4:0][BUS_WIDTH-1:0]  ALU operands a, b, c, d, e (index 0..4).
- alu_reg_en  out  5  ALU input-register enables.
- alu_f_add  out  1  ALU add-only mode.
- alu_result  in  BUS_WIDTH  ALU result. It is combinational from the ALU registers loaded on the previous edge.
- busy  out  1  high in any state other than IDLE.

## Operation
- States:
  - IDLE → ISSUE on handshake.
  - ISSUE (pass counter p = 0..3) → DRAIN after p = 3.
  - DRAIN → DONE.
  - DONE → IDLE on out_valid & out_ready.
- in_ready = (state == IDLE). in_valid is ignored in all other states. On handshake, all in_* are latched into local registers; the inputs are not sampled again.
- ISSUE pass p drives alu_reg_en = 5'b11111 and the following alu_ops {a, b, c, d, e}:
  - p0 Xr: {br, wr, bi, neg(wi), ar}
  - p1 Xi: {br, wi, bi, wr, ai}
  - p2 Yr: {br, neg(wr), bi, wi, ar}
  - p3 Yi: {br, neg(wi), bi, neg(wr), ai}
- neg(v) is a saturating negate: −128 → +127, otherwise −v.
- Bypass: alu_f_add = 1 during ISSUE. In each pass, ops[0], ops[2] and ops[4] all carry ar, ai, br, bi for p0..p3 respectively, and ops[1] = ops[3] = 0. The result equals the value regardless of the ALU's e-mux polarity.
- Outside ISSUE: alu_reg_en = 0, alu_ops = 0, alu_f_add = 0, so the ALU registers hold their values.
- Capture: a one-cycle-delayed copy of (issuing, p) selects which output register loads alu_result.
- Overflow and wrap of the sums are the ALU's behaviour; this block does not saturate results.

## Timing
- Cycle 0: handshake edge.
- Cycles 1–4: pass p0..p3 issued.
- Cycles 2–5: results for p0..p3 captured at the end of each cycle.
- Cycle 6: out_valid = 1 (DONE). Latency is 6 cycles from handshake to out_valid.
- Minimum request spacing is 7 cycles, with out_ready held high.
- DONE stall: out_* and out_valid hold stable until out_ready. After the transfer, out_valid falls the next cycle; out_* keep their values.
- Reset, including reset asserted mid-ISSUE, DRAIN or DONE, forces on the next edge:
  - state IDLE, p = 0, capture-valid 0
  - out_valid 0, out_* 0
  - alu_reg_en 0, alu_f_add 0, alu_ops 0, busy 0
  - in_ready 1 after reset deasserts.
- ALU registers have no reset. Their contents are never captured before this block has issued into them.

## Structure
- Package butterfly_sched_pkg:
  - state enum (IDLE, ISSUE, DRAIN, DONE)
  - 2-bit pass index type
  - constants Q07_MAX = 127, Q07_MIN = −128
  - function sat_neg.
- No sub-module; the operand mux and capture decode are local. The ALU instance is external.

## Test plan
- Butterfly: ar=10, ai=−4, br=20, bi=8, wr=64, wi=−64 → out_xr=24, out_xi=−10, out_yr=−4, out_yi=2; out_valid exactly 6 cycles after the handshake.
- Pass ordering: the same request produces alu_ops in cycle 1 = {20, 64, 8, 64, 10} and in cycle 4 = {20, 64, 8, −64, −4}; alu_reg_en = 1F in cycles 1–4 only.
- Saturating negate: wr=−128 → alu_ops[1] = 127 in the p2 cycle.
- Bypass: A=(5, −7), B=(100, −128) with in_bypass=1 → X=(5, −7), Y=(100, −128); alu_f_add = 1 in cycles 1–4.
- Backpressure: out_ready held low for 10 cycles → outputs stable, in_ready low throughout, and an in_valid pulse during the stall is ignored. After the release, the next request is accepted in IDLE.
- Reset: rst_n low in cycle 3 of a butterfly → next cycle state IDLE, out_valid 0, alu_reg_en 0; a fresh request then completes with correct values.
